// File: rtl/vx_commit_gather.sv
// Commit reassembly: gathers NUM_LANES-wide beats from NUM_INPUTS channels into one
// THREAD_CNT-lane commit, with packet-atomic round-robin arbitration and a registered output.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module vx_commit_gather #(
  parameter int NUM_INPUTS = 2,
  parameter int THREAD_CNT = `NUM_THREADS,
  parameter int NUM_LANES  = THREAD_CNT,
  parameter int UUID_W     = 44,
  parameter int WID_W      = 2,
  parameter int PC_W       = 32,
  parameter int RD_W       = 5,
  parameter int DATA_W     = 32,
  parameter int PID_COUNT  = THREAD_CNT / NUM_LANES,
  parameter int PID_WIDTH  = (PID_COUNT > 1) ? $clog2(PID_COUNT) : 1,
  parameter int IN_W  = UUID_W + WID_W + NUM_LANES + PC_W + 1 + RD_W + NUM_LANES * DATA_W + PID_WIDTH + 2,
  parameter int OUT_W = UUID_W + WID_W + THREAD_CNT + PC_W + 1 + RD_W + THREAD_CNT * DATA_W + PID_WIDTH + 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_INPUTS-1:0]      in_valid,
  input  logic [NUM_INPUTS*IN_W-1:0] in_data,
  output logic [NUM_INPUTS-1:0]      in_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  input  logic                       out_ready,
  output logic                       proto_err
);
  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int OUT_DW = THREAD_CNT * DATA_W;
  localparam int I_PID  = 2;
  localparam int I_DATA = I_PID + PID_WIDTH;
  localparam int I_RD   = I_DATA + NUM_LANES * DATA_W;
  localparam int I_WB   = I_RD + RD_W;
  localparam int I_PC   = I_WB + 1;
  localparam int I_TM   = I_PC + PC_W;
  localparam int I_WID  = I_TM + NUM_LANES;
  localparam int I_UUID = I_WID + WID_W;

  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t                  state_r, state_next_s;
  logic [IDX_W-1:0]        owner_r, owner_next_s, rr_r, rr_next_s;
  logic [IDX_W-1:0]        grant_s, sel_s, cand_idx_s;
  logic                    found_s, ready_s, accept_s, eop_ok_s, err_s, proto_err_r;
  logic [NUM_INPUTS-1:0]   sop_s;
  logic [IN_W-1:0]         beat_s;
  logic [PID_WIDTH-1:0]    pid_s;
  logic [THREAD_CNT-1:0]   asm_tmask_r, tmask_next_s;
  logic [OUT_DW-1:0]       asm_data_r, data_next_s;
  logic [UUID_W-1:0]       asm_uuid_r, hdr_uuid_s;
  logic [WID_W-1:0]        asm_wid_r, hdr_wid_s;
  logic [PC_W-1:0]         asm_pc_r, hdr_pc_s;
  logic                    asm_wb_r, hdr_wb_s;
  logic [RD_W-1:0]         asm_rd_r, hdr_rd_s;
  logic                    out_valid_r;
  logic [OUT_W-1:0]        out_data_r, out_next_s;

  // Round-robin search for an IDLE grant: first sop-valid channel at or after rr.
  always_comb begin
    sop_s      = {NUM_INPUTS{1'b0}};
    found_s    = 1'b0;
    grant_s    = {IDX_W{1'b0}};
    cand_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      sop_s[i] = in_data[i*IN_W + 1];
    end
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand_idx_s = IDX_W'((int'(rr_r) + k) % NUM_INPUTS);
      if (!found_s && in_valid[cand_idx_s] && sop_s[cand_idx_s]) begin
        found_s = 1'b1;
        grant_s = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake, protocol checking and next-state for the lock FSM.
  always_comb begin
    sel_s  = (state_r == COLLECT) ? owner_r : grant_s;
    beat_s = {IN_W{1'b0}};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sel_s == IDX_W'(i)) begin
        beat_s = in_data[i*IN_W +: IN_W];
      end else begin
        beat_s = beat_s;
      end
    end
    // eop beats may only land when the output register is free or draining now.
    eop_ok_s = !out_valid_r || out_ready;
    ready_s  = reset && ((state_r == COLLECT) || found_s) && (!beat_s[0] || eop_ok_s);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = ready_s && (sel_s == IDX_W'(i));
    end
    accept_s     = ready_s && in_valid[sel_s];
    state_next_s = state_r;
    owner_next_s = owner_r;
    rr_next_s    = rr_r;
    err_s        = 1'b0;
    case (state_r)
      IDLE:    err_s = |(in_valid & ~sop_s);
      COLLECT: err_s = accept_s && beat_s[1];
      default: err_s = 1'b0;
    endcase
    if (accept_s && beat_s[0]) begin
      state_next_s = IDLE;
      rr_next_s    = (int'(sel_s) == NUM_INPUTS - 1) ? {IDX_W{1'b0}} : sel_s + 1'b1;
    end else if (accept_s) begin
      state_next_s = COLLECT;
      owner_next_s = sel_s;
    end else begin
      state_next_s = state_r;
    end
  end

  // Merge the current beat into the assembly; a sop beat restarts it with its own header.
  always_comb begin
    pid_s        = (PID_COUNT == 1) ? {PID_WIDTH{1'b0}} : beat_s[I_PID +: PID_WIDTH];
    tmask_next_s = beat_s[1] ? {THREAD_CNT{1'b0}} : asm_tmask_r;
    data_next_s  = asm_data_r;
    for (int l = 0; l < THREAD_CNT; l++) begin
      if ((l / NUM_LANES) == int'(pid_s)) begin
        tmask_next_s[l]                  = beat_s[I_TM + (l % NUM_LANES)];
        data_next_s[l*DATA_W +: DATA_W]  = beat_s[I_DATA + (l % NUM_LANES) * DATA_W +: DATA_W];
      end else begin
        tmask_next_s[l] = tmask_next_s[l];
      end
    end
    hdr_uuid_s = beat_s[1] ? beat_s[I_UUID +: UUID_W] : asm_uuid_r;
    hdr_wid_s  = beat_s[1] ? beat_s[I_WID +: WID_W]   : asm_wid_r;
    hdr_pc_s   = beat_s[1] ? beat_s[I_PC +: PC_W]     : asm_pc_r;
    hdr_wb_s   = beat_s[1] ? beat_s[I_WB]             : asm_wb_r;
    hdr_rd_s   = beat_s[1] ? beat_s[I_RD +: RD_W]     : asm_rd_r;
    out_next_s = {hdr_uuid_s, hdr_wid_s, tmask_next_s, hdr_pc_s, hdr_wb_s, hdr_rd_s,
                  data_next_s, {PID_WIDTH{1'b0}}, 1'b1, 1'b1};
  end

  // Lock FSM, round-robin pointer and protocol-error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      owner_r     <= {IDX_W{1'b0}};
      rr_r        <= {IDX_W{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      owner_r     <= owner_next_s;
      rr_r        <= rr_next_s;
      proto_err_r <= err_s;
    end
  end

  // Assembly register, updated on every accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_tmask_r <= {THREAD_CNT{1'b0}};
      asm_data_r  <= {OUT_DW{1'b0}};
      asm_uuid_r  <= {UUID_W{1'b0}};
      asm_wid_r   <= {WID_W{1'b0}};
      asm_pc_r    <= {PC_W{1'b0}};
      asm_wb_r    <= 1'b0;
      asm_rd_r    <= {RD_W{1'b0}};
    end else if (accept_s) begin
      asm_tmask_r <= tmask_next_s;
      asm_data_r  <= data_next_s;
      asm_uuid_r  <= hdr_uuid_s;
      asm_wid_r   <= hdr_wid_s;
      asm_pc_r    <= hdr_pc_s;
      asm_wb_r    <= hdr_wb_s;
      asm_rd_r    <= hdr_rd_s;
    end else begin
      asm_tmask_r <= asm_tmask_r;
    end
  end

  // Output register: filled by an accepted eop, held until out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
    end else if (accept_s && beat_s[0]) begin
      out_valid_r <= 1'b1;
      out_data_r  <= out_next_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign proto_err = proto_err_r;
endmodule

// File: tb/tb_vx_commit_gather.sv
// Directed and randomized checks of vx_commit_gather (2 channels, 4 threads, 2 lanes/beat)
// against a packet-level reference model.
module tb_vx_commit_gather;
  localparam int IN_W  = 69;
  localparam int OUT_W = 87;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [1:0]          vld = 2'b00;
  logic [IN_W-1:0]     beat_in [2];
  logic [2*IN_W-1:0]   in_data;
  logic [1:0]          in_ready;
  logic                out_valid;
  logic [OUT_W-1:0]    out_data;
  logic                out_ready = 1'b0;
  logic                proto_err;
  int                  n_cmp = 0;
  int                  n_bad = 0;

  assign in_data = {beat_in[1], beat_in[0]};

  vx_commit_gather #(.NUM_INPUTS(2), .THREAD_CNT(4), .NUM_LANES(2), .UUID_W(8), .WID_W(2),
                     .PC_W(32), .RD_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(vld), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .proto_err(proto_err));

  always #5 clk = ~clk;

  // Watchdog: the run must finish well before this deadline.
  initial begin
    #2000000;
    n_bad++;
    $error("FAIL timeout: simulation did not finish within the wait limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mk(input logic [7:0] u, input logic [1:0] w,
      input logic [1:0] tm, input logic [31:0] pc, input logic wb, input logic [4:0] rd,
      input logic [15:0] d, input logic pid, input logic sop, input logic eop);
    return {u, w, tm, pc, wb, rd, d, pid, sop, eop};
  endfunction

  function automatic logic [IN_W-1:0] mkd(input logic [7:0] u, input logic [1:0] tm,
      input logic [31:0] pc, input logic [15:0] d, input logic pid, input logic sop, input logic eop);
    return mk(u, 2'd1, tm, pc, 1'b1, 5'd3, d, pid, sop, eop);
  endfunction

  // Lanes whose tmask bit is clear carry don't-care data; zero them on both sides.
  function automatic logic [OUT_W-1:0] masked(input logic [OUT_W-1:0] o);
    logic [7:0] u; logic [1:0] w; logic [3:0] tm; logic [31:0] pc; logic wb;
    logic [4:0] rd; logic [31:0] d; logic [2:0] tail;
    {u, w, tm, pc, wb, rd, d, tail} = o;
    for (int l = 0; l < 4; l++) begin
      if (!tm[l]) d[l*8 +: 8] = 8'h00;
    end
    return {u, w, tm, pc, wb, rd, d, tail};
  endfunction

  function automatic logic [OUT_W-1:0] expo(input logic [7:0] u, input logic [1:0] w,
      input logic [3:0] tm, input logic [31:0] pc, input logic wb, input logic [4:0] rd,
      input logic [31:0] d);
    return masked({u, w, tm, pc, wb, rd, d, 3'b011});
  endfunction

  function automatic logic [OUT_W-1:0] expd(input logic [7:0] u, input logic [3:0] tm,
      input logic [31:0] pc, input logic [31:0] d);
    return expo(u, 2'd1, tm, pc, 1'b1, 5'd3, d);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase state: per-channel packet being sent and a packet-level model.
  logic [IN_W-1:0]  pk_beat [2][2];
  int               pk_len [2];
  int               pk_pos [2];
  logic [OUT_W-1:0] pk_exp [2];
  int               m_owner, m_rr, m_sel;
  bit               m_pend, m_found;
  logic [OUT_W-1:0] m_head;
  logic [1:0]       exp_rdy;
  logic [7:0]       ru;
  logic [1:0]       rw, rt0, rt1;
  logic [31:0]      rpc;
  logic             rwb;
  logic [4:0]       rrd;
  logic [15:0]      rd0, rd1;
  logic [OUT_W-1:0] held;

  initial begin
    beat_in[0] = mkd(8'h01, 2'b11, 32'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    beat_in[1] = {IN_W{1'b0}};
    vld = 2'b01;
    #7;
    chk("rst_in_ready", in_ready, 2'b00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    tick();
    vld = 2'b00;
    reset = 1'b1;
    tick();

    // single-beat packet
    beat_in[0] = mkd(8'h11, 2'b11, 32'h8000, {8'h0B, 8'h0A}, 1'b0, 1'b1, 1'b1);
    vld = 2'b01;
    #1 chk("single_ready", in_ready, 2'b01);
    tick();
    vld = 2'b00;
    chk("single_valid", out_valid, 1'b1);
    chk("single_out", masked(out_data), expd(8'h11, 4'b0011, 32'h8000, {8'h00, 8'h00, 8'h0B, 8'h0A}));
    out_ready = 1'b1;
    tick();
    chk("single_drain", out_valid, 1'b0);

    // two-beat gather; second beat header must be ignored
    beat_in[0] = mkd(8'h22, 2'b11, 32'h100, {8'h02, 8'h01}, 1'b0, 1'b1, 1'b0);
    vld = 2'b01;
    #1 chk("gather_b0_ready", in_ready, 2'b01);
    tick();
    beat_in[0] = mk(8'h33, 2'd2, 2'b01, 32'h999, 1'b0, 5'd9, {8'hFF, 8'h03}, 1'b1, 1'b0, 1'b1);
    #1 chk("gather_b1_ready", in_ready, 2'b01);
    tick();
    vld = 2'b00;
    chk("gather_out", masked(out_data), expd(8'h22, 4'b0111, 32'h100, {8'h00, 8'h03, 8'h02, 8'h01}));
    tick();

    // skipped pid
    beat_in[0] = mkd(8'h44, 2'b10, 32'h200, {8'h44, 8'h55}, 1'b1, 1'b1, 1'b1);
    vld = 2'b01;
    tick();
    vld = 2'b00;
    chk("skip_pid_out", masked(out_data), expd(8'h44, 4'b1000, 32'h200, {8'h44, 24'h0}));
    tick();

    // contention from reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b0;
    beat_in[0] = mkd(8'hA0, 2'b11, 32'hA0, {8'hA2, 8'hA1}, 1'b0, 1'b1, 1'b0);
    beat_in[1] = mkd(8'hB0, 2'b11, 32'hB0, {8'hB2, 8'hB1}, 1'b0, 1'b1, 1'b0);
    vld = 2'b11;
    #1 chk("cont_grant0", in_ready, 2'b01);
    tick();
    beat_in[0] = mkd(8'hA9, 2'b11, 32'hA9, {8'hA4, 8'hA3}, 1'b1, 1'b0, 1'b1);
    #1 chk("cont_lock0", in_ready, 2'b01);
    tick();
    vld = 2'b10;
    out_ready = 1'b1;
    #1 chk("cont_out0", masked(out_data), expd(8'hA0, 4'b1111, 32'hA0, {8'hA4, 8'hA3, 8'hA2, 8'hA1}));
    chk("cont_grant1", in_ready, 2'b10);
    tick();
    beat_in[1] = mkd(8'hB9, 2'b01, 32'hB9, {8'hB4, 8'hB3}, 1'b1, 1'b0, 1'b1);
    #1 chk("cont_lock1", in_ready, 2'b10);
    tick();
    chk("cont_out1", masked(out_data), expd(8'hB0, 4'b0111, 32'hB0, {8'h00, 8'hB3, 8'hB2, 8'hB1}));
    beat_in[0] = mkd(8'hC0, 2'b01, 32'hC0, {8'h00, 8'hC1}, 1'b0, 1'b1, 1'b1);
    beat_in[1] = mkd(8'hD0, 2'b01, 32'hD0, {8'h00, 8'hD1}, 1'b0, 1'b1, 1'b1);
    vld = 2'b11;
    #1 chk("rr_back_to_ch0", in_ready, 2'b01);
    tick();
    vld = 2'b10;
    #1 chk("rr_then_ch1", in_ready, 2'b10);
    tick();
    vld = 2'b00;
    chk("rr_out_ch1", masked(out_data), expd(8'hD0, 4'b0001, 32'hD0, {24'h0, 8'hD1}));

    // backpressure
    out_ready = 1'b0;
    held = masked(out_data);
    beat_in[0] = mkd(8'hE0, 2'b11, 32'hE0, {8'hE2, 8'hE1}, 1'b0, 1'b1, 1'b0);
    vld = 2'b01;
    #1 chk("bp_noneop_ready", in_ready, 2'b01);
    tick();
    chk("bp_hold1", masked(out_data), held);
    beat_in[0] = mkd(8'hE9, 2'b10, 32'hE9, {8'hE4, 8'hE3}, 1'b1, 1'b0, 1'b1);
    #1 chk("bp_eop_stall", in_ready, 2'b00);
    tick();
    chk("bp_eop_stall2", in_ready, 2'b00);
    chk("bp_hold2", masked(out_data), held);
    chk("bp_valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 2'b01);
    tick();
    vld = 2'b00;
    chk("bp_fill_drain", masked(out_data), expd(8'hE0, 4'b1011, 32'hE0, {8'hE4, 8'h00, 8'hE2, 8'hE1}));
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // reset mid-COLLECT with a pending output
    out_ready = 1'b0;
    beat_in[0] = mkd(8'hF0, 2'b01, 32'hF0, {8'h00, 8'hF1}, 1'b0, 1'b1, 1'b1);
    vld = 2'b01;
    tick();
    beat_in[0] = mkd(8'hF5, 2'b11, 32'hF5, {8'hF7, 8'hF6}, 1'b0, 1'b1, 1'b0);
    tick();
    beat_in[0] = mkd(8'hF5, 2'b11, 32'hF5, {8'hF9, 8'hF8}, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    #1 chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 2'b00);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    #1 chk("nonsop_not_ready", in_ready, 2'b00);
    tick();
    chk("nonsop_proto_err", proto_err, 1'b1);
    chk("nonsop_no_out", out_valid, 1'b0);
    vld = 2'b00;
    tick();
    chk("proto_err_pulse_end", proto_err, 1'b0);

    // sop again mid-packet restarts assembly
    beat_in[0] = mkd(8'h55, 2'b11, 32'h550, {8'h52, 8'h51}, 1'b0, 1'b1, 1'b0);
    vld = 2'b01;
    tick();
    beat_in[0] = mkd(8'h66, 2'b01, 32'h660, {8'h62, 8'h61}, 1'b0, 1'b1, 1'b0);
    #1 chk("resop_ready", in_ready, 2'b01);
    tick();
    chk("resop_proto_err", proto_err, 1'b1);
    beat_in[0] = mkd(8'h77, 2'b10, 32'h770, {8'h72, 8'h71}, 1'b1, 1'b0, 1'b1);
    tick();
    vld = 2'b00;
    chk("resop_err_clear", proto_err, 1'b0);
    chk("resop_out", masked(out_data), expd(8'h66, 4'b1001, 32'h660, {8'h72, 8'h00, 8'h00, 8'h61}));

    // randomized traffic against the packet-level model
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_owner = -1; m_rr = 0; m_pend = 1'b0; m_head = {OUT_W{1'b0}};
    pk_len[0] = 0; pk_len[1] = 0; pk_pos[0] = 0; pk_pos[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (pk_pos[c] == pk_len[c]) begin
          pk_len[c] = int'($urandom_range(1, 2));
          pk_pos[c] = 0;
          ru = 8'($urandom); rw = 2'($urandom); rpc = $urandom; rwb = 1'($urandom);
          rrd = 5'($urandom); rt0 = 2'($urandom); rt1 = 2'($urandom);
          rd0 = 16'($urandom); rd1 = 16'($urandom);
          if (pk_len[c] == 2) begin
            pk_beat[c][0] = mk(ru, rw, rt0, rpc, rwb, rrd, rd0, 1'b0, 1'b1, 1'b0);
            pk_beat[c][1] = mk(8'($urandom), 2'($urandom), rt1, $urandom, 1'($urandom), 5'($urandom),
                               rd1, 1'b1, 1'b0, 1'b1);
            pk_exp[c] = expo(ru, rw, {rt1, rt0}, rpc, rwb, rrd, {rd1, rd0});
          end else if ($urandom_range(0, 1) == 1) begin
            pk_beat[c][0] = mk(ru, rw, rt0, rpc, rwb, rrd, rd0, 1'b1, 1'b1, 1'b1);
            pk_exp[c] = expo(ru, rw, {rt0, 2'b00}, rpc, rwb, rrd, {rd0, 16'h0});
          end else begin
            pk_beat[c][0] = mk(ru, rw, rt0, rpc, rwb, rrd, rd0, 1'b0, 1'b1, 1'b1);
            pk_exp[c] = expo(ru, rw, {2'b00, rt0}, rpc, rwb, rrd, {16'h0, rd0});
          end
        end
        beat_in[c] = pk_beat[c][pk_pos[c]];
        vld[c] = ($urandom_range(0, 99) < 60);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = 2'b00;
      m_found = 1'b0;
      m_sel = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < 2; k++) begin
          if (!m_found && vld[(m_rr + k) % 2] && beat_in[(m_rr + k) % 2][1]) begin
            m_found = 1'b1;
            m_sel = (m_rr + k) % 2;
          end
        end
      end else begin
        m_found = 1'b1;
        m_sel = m_owner;
      end
      if (m_found) exp_rdy[m_sel] = !beat_in[m_sel][0] || !m_pend || out_ready;
      chk("rand_in_ready", in_ready, exp_rdy);
      chk("rand_out_valid", out_valid, m_pend);
      if (m_pend) chk("rand_out_data", masked(out_data), m_head);
      if (m_pend && out_ready) m_pend = 1'b0;
      for (int c = 0; c < 2; c++) begin
        if (exp_rdy[c] && vld[c]) begin
          if (beat_in[c][0]) begin
            m_pend = 1'b1;
            m_head = pk_exp[c];
            m_rr = (c + 1) % 2;
            m_owner = -1;
          end else begin
            m_owner = c;
          end
          pk_pos[c] = pk_pos[c] + 1;
        end
      end
      tick();
      chk("rand_proto_err", proto_err, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
